// File: rtl/mem_lsu_if.sv
// Bus bundle between the pipeline MEM stage, the load/store unit and the data memory.
// The slave modport is the LSU; the master modport is the pipeline plus memory side.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_wr_en;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wr_data;
  logic [31:0] dmem_rd_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dmem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err, dmem_wr_en, dmem_addr, dmem_wr_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dmem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, dmem_wr_en, dmem_addr, dmem_wr_data
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word loads with extension, and stores with read-modify-write
// for sub-word writes against a word-wide, asynchronously read data memory.
module mem_lsu #(
  parameter int DMEM_WORDS = 64
) (
  input  logic     clk,
  input  logic     reset,
  mem_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    RMW_RD = 2'b10,
    WR     = 2'b11
  } state_t;

  localparam logic [1:0]  SZ_BYTE    = 2'b00;
  localparam logic [1:0]  SZ_HALF    = 2'b01;
  localparam logic [1:0]  SZ_WORD    = 2'b10;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DMEM_WORDS);

  state_t      state_r;
  state_t      state_next;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [15:0] wdata_r;
  logic [31:0] wr_word_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;
  logic        accept;
  logic        req_err;

  function automatic logic check_error(input logic [1:0] size, input logic [31:0] addr);
    logic err;
    err = 1'b0;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr[0];
      SZ_WORD: err = (addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    if (addr >= ADDR_LIMIT) begin
      err = 1'b1;
    end else begin
      err = err;
    end
    return err;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [15:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) r[31:16] = wdata;
        else         r[15:0]  = wdata;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept  = bus.req_valid && (state_r == IDLE);
  assign req_err = check_error(bus.req_size, bus.req_addr);

  // Next-state decode; rejected requests never leave IDLE.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (accept && !req_err) begin
          if (!bus.req_we)                  state_next = LOAD;
          else if (bus.req_size == SZ_WORD) state_next = WR;
          else                              state_next = RMW_RD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD:    state_next = IDLE;
      RMW_RD:  state_next = WR;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latches and the registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= 32'h0000_0000;
      size_r       <= 2'b00;
      unsigned_r   <= 1'b0;
      wdata_r      <= 16'h0000;
      wr_word_r    <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_next;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      case (state_r)
        IDLE: begin
          if (accept) begin
            addr_r     <= bus.req_addr;
            size_r     <= bus.req_size;
            unsigned_r <= bus.req_unsigned;
            wdata_r    <= bus.req_wdata[15:0];
            wr_word_r  <= bus.req_wdata;
            if (req_err) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end
          end
        end
        LOAD: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= load_extract(bus.dmem_rd_data, addr_r[1:0], size_r, unsigned_r);
        end
        RMW_RD: wr_word_r <= store_merge(bus.dmem_rd_data, addr_r[1:0], size_r, wdata_r);
        WR:     resp_valid_r <= 1'b1;
        default: resp_valid_r <= 1'b0;
      endcase
    end
  end

  // Memory-side drive: address only while busy, write data and strobe only in WR.
  always_comb begin
    bus.dmem_wr_en   = 1'b0;
    bus.dmem_addr    = 32'h0000_0000;
    bus.dmem_wr_data = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        bus.dmem_addr = 32'h0000_0000;
      end
      LOAD, RMW_RD: begin
        bus.dmem_addr = {addr_r[31:2], 2'b00};
      end
      WR: begin
        bus.dmem_wr_en   = 1'b1;
        bus.dmem_addr    = {addr_r[31:2], 2'b00};
        bus.dmem_wr_data = wr_word_r;
      end
      default: begin
        bus.dmem_wr_en = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;

endmodule
